regfile_compute_engine: RTL and testbench

//  Parametrised two-bank register file with a sequenced compute datapath.

---
 rtl/regfile_compute_engine.sv | 175 +++++++++++++++++
 tb/tb_regfile_compute_engine.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_compute_engine.sv
// Two-bank register file feeding a sequenced add/compare datapath.
// Bank A is W bits wide and bank B is 2W bits wide. A start request runs
// either one operation (single mode) or a run of consecutive entries whose
// results are accumulated (sweep mode).
module regfile_compute_engine #(
    parameter int W    = 4,
    parameter int AW_A = 3,
    parameter int AW_B = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_a_en,
    input  logic [AW_A-1:0]     wr_a_addr,
    input  logic [W-1:0]        wr_a_data,
    input  logic                wr_b_en,
    input  logic [AW_B-1:0]     wr_b_addr,
    input  logic [2*W-1:0]      wr_b_data,
    input  logic [AW_A-1:0]     rd_a1_addr,
    input  logic [AW_A-1:0]     rd_a2_addr,
    input  logic [AW_B-1:0]     rd_b_addr,
    input  logic                mode,
    input  logic [AW_A:0]       count,
    input  logic                start,
    output logic                busy,
    output logic                out_valid,
    output logic [W-1:0]        out1,
    output logic [W-1:0]        out2,
    output logic                out_ovf
);

    localparam int unsigned DepthA = 2 ** AW_A;
    localparam int unsigned DepthB = 2 ** AW_B;
    localparam logic [W-1:0] MaxVal = '1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXEC,
        DONE
    } stateT;

    stateT state;
    stateT nextState;

    logic [W-1:0]     bankA [DepthA];
    logic [2*W-1:0]   bankB [DepthB];

    logic [AW_A-1:0]  ptrA1;
    logic [AW_A-1:0]  ptrA2;
    logic [AW_B-1:0]  ptrB;
    logic             sweepMode;
    logic [AW_A:0]    remaining;

    logic [W-1:0]     opA1;
    logic [W-1:0]     opA2;
    logic [2*W-1:0]   opB;

    logic [W-1:0]     acc;
    logic [W-1:0]     hits;
    logic             ovfAcc;

    logic [W:0]       sum;
    logic             cmp;
    logic [W+1:0]     accSum;
    logic             accSat;
    logic [W:0]       hitsSum;
    logic             hitsSat;
    logic             lastIter;

    // Arithmetic on the registered operands plus saturating accumulator updates
    always_comb begin
        sum      = {1'b0, opA1} + {1'b0, opB[2*W-1:W]};
        cmp      = opA2 > opB[W-1:0];
        accSum   = {2'b00, acc} + {1'b0, sum};
        accSat   = |accSum[W+1:W];
        hitsSum  = {1'b0, hits} + {{W{1'b0}}, cmp};
        hitsSat  = hitsSum[W];
        lastIter = remaining == {{AW_A{1'b0}}, 1'b1};
    end

    assign busy = state != IDLE;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state sequencing
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: if (start) nextState = LOAD;
            LOAD: nextState = EXEC;
            EXEC: nextState = (!sweepMode || lastIter) ? DONE : LOAD;
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Bank writes, operand fetch, accumulation and output registers.
    // Single mode reuses acc/hits/ovfAcc to carry its result into DONE, so
    // DONE copies the same registers to the outputs in both modes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DepthA; i++) bankA[i] <= '0;
            for (int unsigned i = 0; i < DepthB; i++) bankB[i] <= '0;
            ptrA1     <= '0;
            ptrA2     <= '0;
            ptrB      <= '0;
            sweepMode <= 1'b0;
            remaining <= '0;
            opA1      <= '0;
            opA2      <= '0;
            opB       <= '0;
            acc       <= '0;
            hits      <= '0;
            ovfAcc    <= 1'b0;
            out1      <= '0;
            out2      <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (wr_a_en) bankA[wr_a_addr] <= wr_a_data;
            if (wr_b_en) bankB[wr_b_addr] <= wr_b_data;

            out_valid <= state == DONE;

            unique case (state)
                IDLE: begin
                    if (start) begin
                        ptrA1     <= rd_a1_addr;
                        ptrA2     <= rd_a2_addr;
                        ptrB      <= rd_b_addr;
                        sweepMode <= mode;
                        remaining <= (count == '0) ? {{AW_A{1'b0}}, 1'b1} : count;
                        acc       <= '0;
                        hits      <= '0;
                        ovfAcc    <= 1'b0;
                    end
                end
                LOAD: begin
                    opA1 <= bankA[ptrA1];
                    opA2 <= bankA[ptrA2];
                    opB  <= bankB[ptrB];
                end
                EXEC: begin
                    if (sweepMode) begin
                        acc       <= accSat ? MaxVal : accSum[W-1:0];
                        hits      <= hitsSat ? MaxVal : hitsSum[W-1:0];
                        ovfAcc    <= ovfAcc | sum[W] | accSat | hitsSat;
                        ptrA1     <= ptrA1 + 1'b1;
                        ptrA2     <= ptrA2 + 1'b1;
                        ptrB      <= ptrB + 1'b1;
                        remaining <= remaining - 1'b1;
                    end else begin
                        acc    <= sum[W] ? MaxVal : sum[W-1:0];
                        hits   <= cmp ? opA2 : opB[W-1:0];
                        ovfAcc <= sum[W];
                    end
                end
                DONE: begin
                    out1    <= acc;
                    out2    <= hits;
                    out_ovf <= ovfAcc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_compute_engine.sv
// Scoreboard bench for regfile_compute_engine: a reference model computes each
// operation's results from a timestamped log of bank writes.
module tb_regfile_compute_engine;

    localparam int W    = 4;
    localparam int AW_A = 3;
    localparam int AW_B = 4;
    localparam int DepthA = 1 << AW_A;
    localparam int DepthB = 1 << AW_B;
    localparam int Max    = (1 << W) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            wr_a_en = 1'b0;
    logic [AW_A-1:0] wr_a_addr = '0;
    logic [W-1:0]    wr_a_data = '0;
    logic            wr_b_en = 1'b0;
    logic [AW_B-1:0] wr_b_addr = '0;
    logic [2*W-1:0]  wr_b_data = '0;
    logic [AW_A-1:0] rd_a1_addr = '0;
    logic [AW_A-1:0] rd_a2_addr = '0;
    logic [AW_B-1:0] rd_b_addr = '0;
    logic            mode = 1'b0;
    logic [AW_A:0]   count = '0;
    logic            start = 1'b0;
    logic            busy;
    logic            out_valid;
    logic [W-1:0]    out1;
    logic [W-1:0]    out2;
    logic            out_ovf;

    regfile_compute_engine #(.W(W), .AW_A(AW_A), .AW_B(AW_B)) dut (
        .clk(clk), .rst(rst),
        .wr_a_en(wr_a_en), .wr_a_addr(wr_a_addr), .wr_a_data(wr_a_data),
        .wr_b_en(wr_b_en), .wr_b_addr(wr_b_addr), .wr_b_data(wr_b_data),
        .rd_a1_addr(rd_a1_addr), .rd_a2_addr(rd_a2_addr), .rd_b_addr(rd_b_addr),
        .mode(mode), .count(count), .start(start),
        .busy(busy), .out_valid(out_valid),
        .out1(out1), .out2(out2), .out_ovf(out_ovf)
    );

    typedef struct {
        int     o1;
        int     o2;
        int     ovf;
        longint vEdge;
    } expT;

    typedef struct {
        int     bank;
        int     addr;
        int     data;
        longint wEdge;
    } wrT;

    expT    sbq[$];
    wrT     wlog[$];
    int     checks = 0;
    int     errors = 0;
    longint edgeCnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt++;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Bank contents as seen by a read sampled at edge e (same-edge writes not yet visible)
    function automatic int bankVal(input int bank, input int addr, input longint e);
        for (int i = wlog.size() - 1; i >= 0; i--)
            if (wlog[i].bank == bank && wlog[i].addr == addr && wlog[i].wEdge < e)
                return wlog[i].data;
        return 0;
    endfunction

    // Reference result of one start request seen at edge startEdge
    function automatic expT model(input bit md, input int a1, input int a2, input int b,
                                  input int cnt, input longint startEdge);
        expT r;
        int iters;
        int acc;
        int hits;
        int ovf;
        iters = md ? ((cnt == 0) ? 1 : cnt) : 1;
        acc = 0;
        hits = 0;
        ovf = 0;
        for (int i = 0; i < iters; i++) begin
            longint le;
            int x, y, z, hi, lo, s;
            le = startEdge + 1 + 2 * i;
            x  = bankVal(0, (a1 + i) % DepthA, le);
            y  = bankVal(0, (a2 + i) % DepthA, le);
            z  = bankVal(1, (b + i) % DepthB, le);
            hi = z / (1 << W);
            lo = z % (1 << W);
            s  = x + hi;
            if (!md) begin
                acc  = (s > Max) ? Max : s;
                ovf  = (s > Max) ? 1 : 0;
                hits = (y > lo) ? y : lo;
            end else begin
                if (s > Max) ovf = 1;
                acc = acc + s;
                if (acc > Max) begin acc = Max; ovf = 1; end
                if (y > lo) hits++;
                if (hits > Max) begin hits = Max; ovf = 1; end
            end
        end
        r.o1 = acc;
        r.o2 = hits;
        r.ovf = ovf;
        r.vEdge = startEdge + 2 * iters + 1;
        return r;
    endfunction

    // Monitor: every out_valid pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst && out_valid) begin
            expT e;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: out_valid=1 with nothing pending, expected 0");
            end else begin
                e = sbq.pop_front();
                check("out1", int'(out1), e.o1);
                check("out2", int'(out2), e.o2);
                check("out_ovf", int'(out_ovf), e.ovf);
                check("valid_edge", int'(edgeCnt), int'(e.vEdge));
                check("busy_at_valid", int'(busy), 0);
            end
        end
    end

    task automatic clearWrites();
        wr_a_en = 1'b0;
        wr_b_en = 1'b0;
    endtask

    task automatic driveWrite(input int bank, input int addr, input int data);
        if (bank == 0) begin
            wr_a_en = 1'b1;
            wr_a_addr = AW_A'(addr);
            wr_a_data = W'(data);
        end else begin
            wr_b_en = 1'b1;
            wr_b_addr = AW_B'(addr);
            wr_b_data = (2*W)'(data);
        end
    endtask

    task automatic wr(input int bank, input int addr, input int data);
        @(negedge clk);
        driveWrite(bank, addr, data);
        wlog.push_back('{bank, addr, data, edgeCnt + 1});
        @(negedge clk);
        clearWrites();
    endtask

    task automatic randWrites(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clearWrites();
            if ($urandom_range(0, 1) == 1) begin
                int a, d;
                a = int'($urandom_range(0, DepthA - 1));
                d = int'($urandom_range(0, Max));
                driveWrite(0, a, d);
                wlog.push_back('{0, a, d, edgeCnt + 1});
            end
            if ($urandom_range(0, 1) == 1) begin
                int a, d;
                a = int'($urandom_range(0, DepthB - 1));
                d = int'($urandom_range(0, 255));
                driveWrite(1, a, d);
                wlog.push_back('{1, a, d, edgeCnt + 1});
            end
        end
        @(negedge clk);
        clearWrites();
    endtask

    // Issue one request; optionally inject a write injK edges after start and
    // pulse start while busy. Waits (bounded) until the result has been checked.
    task automatic runOp(input bit md, input int a1, input int a2, input int b, input int cnt,
                         input int injK, input int injBank, input int injAddr, input int injData,
                         input bit pulses);
        longint startEdge;
        int iters;
        int t;
        @(negedge clk);
        iters = md ? ((cnt == 0) ? 1 : cnt) : 1;
        startEdge = edgeCnt + 1;
        if (injK > 0) wlog.push_back('{injBank, injAddr, injData, startEdge + injK});
        sbq.push_back(model(md, a1, a2, b, cnt, startEdge));
        mode = md;
        rd_a1_addr = AW_A'(a1);
        rd_a2_addr = AW_A'(a2);
        rd_b_addr = AW_B'(b);
        count = (AW_A+1)'(cnt);
        start = 1'b1;
        for (int k = 1; k <= 2 * iters; k++) begin
            @(negedge clk);
            clearWrites();
            start = (pulses && k >= 2 && k <= 2 * iters - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (k == 1) check("busy_running", int'(busy), 1);
            if (k == injK) driveWrite(injBank, injAddr, injData);
        end
        @(negedge clk);
        clearWrites();
        start = 1'b0;
        t = 0;
        while (sbq.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (sbq.size() != 0) begin
            check("result_timeout", sbq.size(), 0);
            sbq.delete();
        end
    endtask

    initial begin
        // Reset asserted from time zero
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_out1", int'(out1), 0);
        rst = 1'b1;

        // Single operation
        wr(0, 1, 5);
        wr(0, 2, 9);
        wr(1, 3, 'h73);
        runOp(1'b0, 1, 2, 3, 0, 0, 0, 0, 0, 1'b0);

        // Saturating single operation
        wr(0, 1, 'hC);
        wr(1, 3, 'h55);
        runOp(1'b0, 1, 2, 3, 0, 0, 0, 0, 0, 1'b0);

        // Sweep wrapping both banks
        wr(0, 6, 1);
        wr(0, 7, 2);
        wr(0, 0, 3);
        wr(1, 14, 'h10);
        wr(1, 15, 'h10);
        wr(1, 0, 'h10);
        runOp(1'b1, 6, 6, 14, 3, 0, 0, 0, 0, 1'b0);

        // Ignored start pulses, write to B[15] during the LOAD of entry 14
        wr(1, 15, 'h10);
        runOp(1'b1, 6, 6, 14, 3, 1, 1, 15, 'h20, 1'b1);

        // count of zero runs one iteration
        runOp(1'b1, 6, 6, 14, 0, 0, 0, 0, 0, 1'b0);

        // Write to the entry being loaded on the same edge: old value is used
        runOp(1'b0, 1, 2, 3, 0, 1, 0, 1, 2, 1'b0);

        // Sweep saturating the accumulator
        for (int i = 0; i < DepthA; i++) wr(0, i, 'hF);
        runOp(1'b1, 0, 0, 0, 8, 0, 0, 0, 0, 1'b0);

        // Asynchronous reset in the middle of a sweep
        @(negedge clk);
        mode = 1'b1;
        rd_a1_addr = '0;
        rd_a2_addr = '0;
        rd_b_addr = '0;
        count = 4'd8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_out1", int'(out1), 0);
        check("mid_rst_out2", int'(out2), 0);
        check("mid_rst_ovf", int'(out_ovf), 0);
        sbq.delete();
        wlog.delete();
        @(negedge clk);
        rst = 1'b1;

        // Every bank entry reads back as zero after reset
        runOp(1'b1, 0, 0, 0, 8, 0, 0, 0, 0, 1'b0);
        runOp(1'b1, 0, 0, 8, 8, 0, 0, 0, 0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            bit md;
            int cnt, iters, injK, injBank;
            randWrites(int'($urandom_range(1, 6)));
            md = 1'($urandom_range(0, 1));
            cnt = int'($urandom_range(0, DepthA));
            iters = md ? ((cnt == 0) ? 1 : cnt) : 1;
            injK = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 2 * iters));
            injBank = int'($urandom_range(0, 1));
            runOp(md,
                  int'($urandom_range(0, DepthA - 1)),
                  int'($urandom_range(0, DepthA - 1)),
                  int'($urandom_range(0, DepthB - 1)),
                  cnt, injK, injBank,
                  int'($urandom_range(0, (injBank == 0) ? DepthA - 1 : DepthB - 1)),
                  int'($urandom_range(0, (injBank == 0) ? Max : 255)),
                  1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        check("leftover_expectations", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
